sys_rr_arbiter: RTL and testbench
=================================

// Module: sys_rr_arbiter
//
// PURPOSE
//   N-input round-robin arbiter with valid/ready handshakes. Shares one downstream
//   sink between N_REQ requesters. Payload is registered in a single output stage,
//   and a u32 grant counter is kept for debug and statistics.
//   Sits in lib_sys and uses the sys_pkg_type scalar types (u8/u32).
//
// PARAMETERS
//   N_REQ    4   number of requesters, 2..16
//   DATA_W   32  payload width per requester, bits
//
// PORTS
//   clk          in   1              system clock, rising edge
//   rst_n        in   1              asynchronous active-low reset
//   req_valid    in   N_REQ          per-requester valid
//   req_data     in   N_REQ*DATA_W   packed payloads; requester i at [i*DATA_W +: DATA_W]
//   req_ready    out  N_REQ          per-requester ready (one-hot or zero)
//   out_valid    out  1              output stage holds a beat
//   out_data     out  DATA_W         registered payload
//   out_idx      out  u8             index of the requester that sourced out_data
//   out_ready    in   1              sink accepts the beat
//   grant_cnt    out  u32            total accepted requester beats, wraps 2^32-1 -> 0
//
// BEHAVIOUR
//   - Reset (async assert, sync release): out_valid=0, out_data=0, out_idx=0,
//     grant_cnt=0, ptr=N_REQ-1 (requester 0 is first in priority), FSM=EMPTY.
//   - FSM states:
//       EMPTY: stage free.
//       FULL:  stage holds a beat.
//     Transitions:
//       EMPTY->FULL when any req_valid.
//       FULL->EMPTY on out_ready with no new grant.
//       FULL->FULL on out_ready with a new grant (back-to-back, no bubble).
//       FULL stays FULL while out_ready=0.
//   - Stage can load when: stage_free = !out_valid | out_ready.
//   - Grant: the first i with req_valid[i], searching from ptr+1 upward, modulo N_REQ.
//     req_ready[i]=1 only for the granted i, and only while stage_free.
//     req_ready is combinational from req_valid, out_valid and out_ready.
//   - On accept (req_valid[i] & req_ready[i]): in the same edge, out_data<=req_data[i],
//     out_idx<=i, out_valid<=1, ptr<=i, grant_cnt<=grant_cnt+1.
//   - Latency: one cycle, request accept -> out_valid.
//     Throughput: one beat per cycle while out_ready=1.
//   - Fairness: a continuously asserting requester waits at most N_REQ-1 grants.
//   - Stall: out_valid=1 & out_ready=0 -> req_ready=0 for all;
//     out_data and out_idx held stable.
//   - Requesters may drop req_valid before ready (no lock), and ptr is unchanged.
//     The sink sees AXI-style rules: once out_valid=1 it stays until out_ready.
//   - Wrap-around: ptr=N_REQ-1 -> the search starts at 0.
//     grant_cnt wraps silently, no flag.
//   - No valid requests: req_ready=0, ptr held.
//   - Reset mid-transfer: the pending beat is dropped, all state as at reset.
//   - N_REQ outside 2..16 or DATA_W<1: elaboration-time $error.
//
// STRUCTURE
//   - sys_pkg_type (existing): u8, u32.
//   - New package sys_pkg_arb:
//       typedef enum logic {ARB_EMPTY, ARB_FULL} arb_state_t;
//       localparam ARB_MAX_REQ = 16.
//   - Sub-module sys_rr_pick: combinational round-robin picker.
//       Inputs:  req vector, ptr.
//       Outputs: one-hot grant, grant index, any_valid.
//       Implemented with double-width masked priority encoding.
//       Top module holds the ptr, output-stage and counter registers.
//
// TESTING
//   - Reset, then all 4 valid and out_ready=1 held ->
//     grants in order 0,1,2,3,0; out_idx follows one cycle later; grant_cnt=5.
//   - Only req 2 valid, out_ready=1 ->
//     a beat every cycle, out_idx=2, no bubbles; ptr stays 2.
//   - out_ready=0 for 3 cycles while out_valid=1 ->
//     req_ready=0 for all; out_data/out_idx stable; then accepts on release.
//   - ptr=3 with reqs 1 and 3 valid ->
//     grant 1 (wrap); next grant 3; next grant 1.
//   - grant_cnt preloaded to 32'hFFFF_FFFF by force, one accept -> grant_cnt=0.
//   - rst_n asserted while out_valid=1 ->
//     out_valid=0 immediately (async); next grant after release goes to req 0.

Source files
------------

// File: rtl/sys_rr_arbiter_pkg.sv
// Shared scalar types and arbiter-specific types for lib_sys.

package sys_pkg_type;
    typedef logic [7:0]  u8;
    typedef logic [31:0] u32;
endpackage

package sys_pkg_arb;
    typedef enum logic {ARB_EMPTY = 1'b0, ARB_FULL = 1'b1} arb_state_t;
    localparam int ARB_MAX_REQ = 16;
endpackage

// File: rtl/sys_rr_arbiter_pick.sv
// Combinational round-robin picker: lowest requester strictly above ptr wins,
// wrapping to the lowest requester overall when none sits above ptr.

module sys_rr_pick
    import sys_pkg_arb::*;
#(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             any_valid
);

    logic [N_REQ-1:0]   mask;
    logic [2*N_REQ-1:0] dbl;
    logic               found;

    // Lower half holds requests above ptr, upper half the full vector, so a single
    // low-to-high priority scan yields the wrapped round-robin winner.
    always_comb begin
        mask      = '0;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            mask[i] = (i > int'(ptr));
        end
        dbl = {req, req & mask};
        for (int j = 0; j < 2 * N_REQ; j++) begin
            if (!found && dbl[j]) begin
                found     = 1'b1;
                grant_idx = PTR_W'(j % N_REQ);
            end
        end
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
        any_valid = |req;
    end

endmodule

// File: rtl/sys_rr_arbiter.sv
// N-input round-robin arbiter with valid/ready handshakes, a single registered
// output stage and a free-running accepted-beat counter.

module sys_rr_arbiter
    import sys_pkg_type::*;
    import sys_pkg_arb::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output u8                       out_idx,
    input  logic                    out_ready,
    output u32                      grant_cnt
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if (N_REQ < 2 || N_REQ > ARB_MAX_REQ || DATA_W < 1) begin : g_param_check
        $error("sys_rr_arbiter: N_REQ must be 2..16 and DATA_W >= 1");
    end

    arb_state_t       state_p0;
    logic [PTR_W-1:0] ptr_p0;
    u32               cnt_p0;

    logic [N_REQ-1:0]  pick_grant;
    logic [PTR_W-1:0]  pick_idx;
    logic              any_valid;
    logic              stage_free;
    logic              accept;
    logic [DATA_W-1:0] sel_data;

    sys_rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req       (req_valid),
        .ptr       (ptr_p0),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any_valid (any_valid)
    );

    assign out_valid  = (state_p0 == ARB_FULL);
    assign stage_free = !out_valid || out_ready;
    assign req_ready  = stage_free ? pick_grant : '0;
    assign accept     = stage_free && any_valid;
    assign sel_data   = req_data[int'(pick_idx)*DATA_W +: DATA_W];
    assign grant_cnt  = cnt_p0;

    // Stage occupancy: refill back-to-back whenever the stage frees and someone asks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p0 <= ARB_EMPTY;
        end else if (stage_free) begin
            state_p0 <= any_valid ? ARB_FULL : ARB_EMPTY;
        end
    end

    // ---- output stage p0: capture granted payload, source index and new priority pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_idx  <= '0;
            ptr_p0   <= PTR_W'(N_REQ - 1);
        end else if (accept) begin
            out_data <= sel_data;
            out_idx  <= u8'(pick_idx);
            ptr_p0   <= pick_idx;
        end
    end

    // Accepted-beat counter, wraps silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p0 <= '0;
        end else if (accept) begin
            cnt_p0 <= cnt_p0 + 32'd1;
        end
    end

endmodule

// File: tb/tb_sys_rr_arbiter.sv
// Directed bench for sys_rr_arbiter (N_REQ=4, DATA_W=32).

module tb_sys_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [7:0]        out_idx;
    logic              out_ready;
    logic [31:0]       grant_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    sys_rr_arbiter #(.N_REQ(N), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_ready (out_ready),
        .grant_cnt (grant_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic set_data(input logic [31:0] base);
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = base + 32'(i);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int ord1 [5] = '{0, 1, 2, 3, 0};
    int ord4 [3] = '{1, 3, 1};

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        out_ready = 1'b0;
        set_data(32'hA0);
        tick();
        tick();

        // reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data",  out_data,  0);
        chk("rst_out_idx",   out_idx,   0);
        chk("rst_grant_cnt", grant_cnt, 0);
        chk("rst_req_ready", req_ready, 0);
        rst_n = 1'b1;

        // all requesters valid, sink always ready: 0,1,2,3,0
        req_valid = 4'hF;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1 chk("t1_req_ready", req_ready, 64'(1 << ord1[k]));
            tick();
            chk("t1_out_valid", out_valid, 1);
            chk("t1_out_idx",   out_idx,   ord1[k]);
            chk("t1_out_data",  out_data,  32'hA0 + ord1[k]);
        end
        chk("t1_grant_cnt", grant_cnt, 5);

        // single requester 2 streaming back-to-back
        req_valid = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            #1 chk("t2_req_ready", req_ready, 4'b0100);
            tick();
            chk("t2_out_valid", out_valid, 1);
            chk("t2_out_idx",   out_idx,   2);
        end
        chk("t2_grant_cnt", grant_cnt, 8);

        // stall: sink not ready for 3 cycles
        out_ready = 1'b0;
        req_valid = 4'hF;
        set_data(32'hB0);
        for (int k = 0; k < 3; k++) begin
            #1 chk("t3_req_ready_stall", req_ready, 0);
            tick();
            chk("t3_out_valid", out_valid, 1);
            chk("t3_out_idx",   out_idx,   2);
            chk("t3_out_data",  out_data,  32'hA2);
        end
        out_ready = 1'b1;
        #1 chk("t3_req_ready_release", req_ready, 4'b1000);
        tick();
        chk("t3_out_idx_release",  out_idx,   3);
        chk("t3_out_data_release", out_data,  32'hB3);
        chk("t3_grant_cnt",        grant_cnt, 9);

        // ptr=3, requesters 1 and 3: wrap to 1, then 3, then 1
        req_valid = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            #1 chk("t4_req_ready", req_ready, 64'(1 << ord4[k]));
            tick();
            chk("t4_out_idx",  out_idx,  ord4[k]);
            chk("t4_out_data", out_data, 32'hB0 + ord4[k]);
        end
        chk("t4_grant_cnt", grant_cnt, 12);
        req_valid = '0;
        #1 chk("t4_req_ready_idle", req_ready, 0);
        tick();
        chk("t4_out_valid_drain", out_valid, 0);

        // counter wrap
        force dut.cnt_p0 = 32'hFFFF_FFFF;
        #1 release dut.cnt_p0;
        chk("t5_grant_cnt_pre", grant_cnt, 32'hFFFF_FFFF);
        req_valid = 4'b0001;
        #1 chk("t5_req_ready", req_ready, 4'b0001);
        tick();
        chk("t5_grant_cnt_wrap", grant_cnt, 0);
        chk("t5_out_idx",        out_idx,   0);

        // asynchronous reset while a beat is held
        req_valid = '0;
        out_ready = 1'b0;
        #2 chk("t6_out_valid_held", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_out_valid_rst", out_valid, 0);
        chk("t6_grant_cnt_rst", grant_cnt, 0);
        chk("t6_out_idx_rst",   out_idx,   0);
        tick();
        rst_n     = 1'b1;
        req_valid = 4'hF;
        out_ready = 1'b1;
        #1 chk("t6_req_ready_after", req_ready, 4'b0001);
        tick();
        chk("t6_out_idx_after",   out_idx,   0);
        chk("t6_out_valid_after", out_valid, 1);
        chk("t6_grant_cnt_after", grant_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
